// File: rtl/queue_mem_select_if.sv
//------------------------------------------------------------------------------
// Module      : queue_mem_select_if
// Description : Slot-request / issue-output bundle of the issue-select stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface queue_mem_select_if #(
  parameter int SLOTS     = 8,
  parameter int WIDTH_O   = 23,
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_BRM = 3
);
  logic [SLOTS-1:0]         i_request;
  logic [SLOTS*WIDTH_O-1:0] i_rslot;
  logic [SLOTS-1:0]         o_grant;
  logic [2**WIDTH_BRM-1:0]  i_brkill;
  logic                     o_valid;
  logic [WIDTH_O-1:0]       o_data;
  logic                     i_ready;
  logic [WIDTH_REG-1:0]     o_wdest;
  logic                     o_wdest_val;

  modport master (
    output i_request, i_rslot, i_brkill, i_ready,
    input  o_grant, o_valid, o_data, o_wdest, o_wdest_val
  );

  modport slave (
    input  i_request, i_rslot, i_brkill, i_ready,
    output o_grant, o_valid, o_data, o_wdest, o_wdest_val
  );
endinterface

`default_nettype wire

// File: rtl/queue_mem_select.sv
//------------------------------------------------------------------------------
// Module      : queue_mem_select
// Description : Round-robin issue select with a killable valid/ready issue register.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module queue_mem_select #(
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_TAG = 3,
  parameter int WIDTH_BRM = 3,
  parameter int SLOTS     = 8,   // power of two, >= 2
  parameter int WIDTH_O   = WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG + 2
) (
  input wire                  i_clk,
  input wire                  i_rst_n,
  queue_mem_select_if.slave   bus
);

  localparam int c_PTR_W  = $clog2(SLOTS);
  localparam int c_RD_LSB = 2*WIDTH_REG + 2;

  logic                r_valid;
  logic [WIDTH_O-1:0]  r_data;
  logic [c_PTR_W-1:0]  r_ptr;

  logic [WIDTH_O-1:0]  w_slot [SLOTS];
  logic [SLOTS-1:0]    w_elig;
  logic                w_held_kill;
  logic                w_out_valid;
  logic                w_fire;
  logic                w_can_load;
  logic                w_found;
  logic                w_load;
  logic [c_PTR_W-1:0]  w_sel;
  logic [c_PTR_W-1:0]  w_idx;

  generate
    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
      assign w_slot[k] = bus.i_rslot[k*WIDTH_O +: WIDTH_O];
      assign w_elig[k] = bus.i_request[k] &
                         ~bus.i_brkill[w_slot[k][WIDTH_O-1 -: WIDTH_BRM]];
    end
  endgenerate

  // A held op whose branch is killed is hidden at once so it can never be accepted.
  assign w_held_kill = r_valid & bus.i_brkill[r_data[WIDTH_O-1 -: WIDTH_BRM]];
  assign w_out_valid = r_valid & ~w_held_kill;
  assign w_fire      = w_out_valid & bus.i_ready;
  assign w_can_load  = ~w_out_valid | bus.i_ready;

  // Scan downward so the lowest offset from the pointer wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    w_idx   = r_ptr;
    for (int j = SLOTS-1; j >= 0; j--) begin
      w_idx = r_ptr + c_PTR_W'(j);
      if (w_elig[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_load = w_found & w_can_load & i_rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_slot[w_sel];
      r_ptr   <= w_sel + c_PTR_W'(1);
    end else if (w_fire | w_held_kill) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.o_grant     = w_load ? ({{(SLOTS-1){1'b0}}, 1'b1} << w_sel) : '0;
  assign bus.o_valid     = w_out_valid;
  assign bus.o_data      = r_data;
  assign bus.o_wdest     = r_data[c_RD_LSB +: WIDTH_REG];
  assign bus.o_wdest_val = w_fire;

endmodule

`default_nettype wire

// File: tb/tb_queue_mem_select.sv
//------------------------------------------------------------------------------
// Module      : tb_queue_mem_select
// Description : Scoreboard bench for queue_mem_select with a reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_queue_mem_select;

  localparam int WIDTH_REG = 5;
  localparam int WIDTH_TAG = 3;
  localparam int WIDTH_BRM = 3;
  localparam int SLOTS     = 8;
  localparam int WIDTH_O   = WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG + 2;
  localparam int NKILL     = 2**WIDTH_BRM;
  localparam int RD_LSB    = 2*WIDTH_REG + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [WIDTH_O-1:0] pay [SLOTS];
  logic [WIDTH_O-1:0] exp_q [$];
  bit                 m_valid;
  logic [WIDTH_O-1:0] m_data;
  int                 m_ptr;

  logic [SLOTS-1:0]     g_grant;
  logic                 g_valid, g_wdv;
  logic [WIDTH_REG-1:0] g_wdest;
  logic [WIDTH_O-1:0]   g_data;

  always #5 clk = ~clk;

  queue_mem_select_if #(.SLOTS(SLOTS), .WIDTH_O(WIDTH_O),
                        .WIDTH_REG(WIDTH_REG), .WIDTH_BRM(WIDTH_BRM)) bus ();

  queue_mem_select #(.WIDTH_REG(WIDTH_REG), .WIDTH_TAG(WIDTH_TAG),
                     .WIDTH_BRM(WIDTH_BRM), .SLOTS(SLOTS), .WIDTH_O(WIDTH_O)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  function automatic logic [WIDTH_O-1:0] mk(int brm, int tag, int rd, int rt, int rs, int v);
    return {WIDTH_BRM'(brm), WIDTH_TAG'(tag), WIDTH_REG'(rd), WIDTH_REG'(rt), WIDTH_REG'(rs), 2'(v)};
  endfunction

  function automatic int brm_of(logic [WIDTH_O-1:0] p);
    return int'(p >> (WIDTH_O - WIDTH_BRM));
  endfunction

  function automatic int rd_of(logic [WIDTH_O-1:0] p);
    return int'(p >> RD_LSB) % (2**WIDTH_REG);
  endfunction

  function automatic logic [WIDTH_O-1:0] rand_pay();
    return mk($urandom_range(0, NKILL-1), $urandom_range(0, 7), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Entered and left at posedge+1: drives one cycle, checks combinational outputs, advances the model.
  task automatic cycle(input logic [SLOTS-1:0] req, input logic [NKILL-1:0] kill, input bit rdy);
    bit held_kill, ovalid, can_load;
    int gk, k;
    bus.i_request = req;
    bus.i_brkill  = kill;
    bus.i_ready   = rdy;
    for (int s = 0; s < SLOTS; s++) bus.i_rslot[s*WIDTH_O +: WIDTH_O] = pay[s];
    #1;
    g_grant = bus.o_grant;
    g_valid = bus.o_valid;
    g_wdv   = bus.o_wdest_val;
    g_wdest = bus.o_wdest;
    g_data  = bus.o_data;
    held_kill = m_valid && kill[brm_of(m_data)];
    ovalid    = m_valid && !held_kill;
    can_load  = !ovalid || rdy;
    gk = -1;
    if (can_load)
      for (int off = 0; off < SLOTS && gk < 0; off++) begin
        k = (m_ptr + off) % SLOTS;
        if (req[k] && !kill[brm_of(pay[k])]) gk = k;
      end
    check("grant", 64'(g_grant), (gk >= 0) ? (64'd1 << gk) : 64'd0);
    check("valid", 64'(g_valid), 64'(ovalid));
    check("wdest_val", 64'(g_wdv), 64'(ovalid && rdy));
    if (m_valid) check("held_data", 64'(g_data), 64'(m_data));
    if (held_kill) void'(exp_q.pop_front());
    if (gk >= 0) begin
      exp_q.push_back(pay[gk]);
      m_valid = 1'b1;
      m_data  = pay[gk];
      m_ptr   = (gk + 1) % SLOTS;
    end else if ((ovalid && rdy) || held_kill) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.i_request = '0;
    bus.i_brkill  = '0;
    bus.i_ready   = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(bus.o_valid), 64'd0);
    check("rst_data", 64'(bus.o_data), 64'd0);
    check("rst_grant", 64'(bus.o_grant), 64'd0);
    check("rst_wdest", 64'(bus.o_wdest), 64'd0);
    check("rst_wdv", 64'(bus.o_wdest_val), 64'd0);
    m_valid = 1'b0;
    m_data  = '0;
    m_ptr   = 0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted op must be the oldest outstanding expected op.
  initial begin
    logic [WIDTH_O-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL issue_unexpected: got 0x%0h, want no issue at %0t", bus.o_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("issue_data", 64'(bus.o_data), 64'(e));
          check("issue_wdest", 64'(bus.o_wdest), 64'(rd_of(e)));
        end
      end
    end
  end

  initial begin
    logic [WIDTH_O-1:0] saved;
    logic [SLOTS-1:0]   rr_exp [6];
    rr_exp = '{8'h01, 8'h04, 8'h80, 8'h01, 8'h04, 8'h80};
    bus.i_rslot = '0;
    for (int s = 0; s < SLOTS; s++) pay[s] = '0;
    do_reset();

    for (int i = 0; i < 5; i++) begin
      cycle('0, '0, 1'b1);
      check("idle_data", 64'(g_data), 64'd0);
    end

    // Kill at select: slot1's branch is killed, slot4 wins.
    for (int s = 0; s < SLOTS; s++) pay[s] = rand_pay();
    pay[1] = mk(2, 1, 3, 4, 5, 1);
    pay[4] = mk(0, 2, 6, 7, 8, 3);
    saved  = pay[4];
    cycle(8'b0001_0010, 8'b0000_0100, 1'b1);
    check("selkill_grant", 64'(g_grant), 64'h10);
    cycle('0, '0, 1'b1);
    check("selkill_data", 64'(g_data), 64'(saved));

    // Round robin from a freshly reset pointer.
    do_reset();
    pay[0] = mk(0, 0, 10, 1, 1, 1);
    pay[2] = mk(0, 1, 11, 2, 2, 1);
    pay[7] = mk(0, 2, 12, 3, 3, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(8'b1000_0101, '0, 1'b1);
      check("rr_grant", 64'(g_grant), 64'(rr_exp[i]));
      if (i > 0) check("rr_valid", 64'(g_valid), 64'd1);
    end

    // Backpressure on a held op.
    cycle('0, '0, 1'b1);
    pay[3] = mk(0, 3, 9, 4, 5, 2);
    saved  = pay[3];
    cycle(8'h08, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(8'h08, '0, 1'b0);
      check("stall_grant", 64'(g_grant), 64'd0);
      check("stall_data", 64'(g_data), 64'(saved));
    end
    cycle('0, '0, 1'b1);
    check("stall_wdv", 64'(g_wdv), 64'd1);
    check("stall_wdest", 64'(g_wdest), 64'd9);
    cycle('0, '0, 1'b1);
    check("stall_wdv_once", 64'(g_wdv), 64'd0);

    // Kill of a held op, then kill concurrent with a new grant.
    pay[6] = mk(5, 4, 13, 1, 2, 3);
    cycle(8'h40, '0, 1'b0);
    cycle('0, '0, 1'b0);
    cycle('0, 8'b0010_0000, 1'b0);
    check("heldkill_valid", 64'(g_valid), 64'd0);
    check("heldkill_wdv", 64'(g_wdv), 64'd0);
    cycle('0, '0, 1'b1);
    check("heldkill_cleared", 64'(g_valid), 64'd0);
    cycle(8'h40, '0, 1'b0);
    cycle(8'h40, '0, 1'b0);
    pay[0] = mk(0, 5, 14, 2, 3, 1);
    saved  = pay[0];
    cycle(8'h01, 8'b0010_0000, 1'b0);
    check("killswap_grant", 64'(g_grant), 64'h01);
    cycle('0, '0, 1'b1);
    check("killswap_data", 64'(g_data), 64'(saved));
    check("killswap_valid", 64'(g_valid), 64'd1);

    // Asynchronous reset while an op is held.
    pay[2] = mk(1, 6, 15, 3, 4, 2);
    cycle(8'h04, '0, 1'b0);
    cycle('0, '0, 1'b0);
    check("pre_rst_valid", 64'(g_valid), 64'd1);
    do_reset();
    for (int s = 0; s < SLOTS; s++) pay[s] = rand_pay();
    cycle(8'hFF, '0, 1'b1);
    check("post_rst_grant", 64'(g_grant), 64'h01);

    // Randomized traffic with occasional kills and resets.
    for (int c = 0; c < 1500; c++) begin
      logic [NKILL-1:0] kill;
      for (int s = 0; s < SLOTS; s++) pay[s] = rand_pay();
      kill = ($urandom_range(0, 3) == 0) ? NKILL'($urandom) : '0;
      cycle(SLOTS'($urandom), kill, $urandom_range(0, 3) != 0);
      if (c % 500 == 499) do_reset();
    end

    for (int i = 0; i < 3; i++) cycle('0, '0, 1'b1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
